// File: rtl/alu_exec_seq_pkg.sv
// Shared definitions for the ALU execute sequencer: op codes, FSM states,
// instruction field positions and small op-classification helpers.
package alu_exec_seq_pkg;

  localparam int NREG   = 4;
  localparam int AW     = 2;
  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
  localparam logic [OP_W-1:0] OP_NAND = 3'b010;
  localparam logic [OP_W-1:0] OP_CMP  = 3'b011;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b100;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b101;
  localparam logic [OP_W-1:0] OP_EQ   = 3'b110;
  localparam logic [OP_W-1:0] OP_NOP7 = 3'b111;

  // Instruction layout: [7:5] op, [4:3] rd, [2:1] rs, [0] unused
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 5;
  localparam int RD_MSB = 4;
  localparam int RD_LSB = 3;
  localparam int RS_MSB = 2;
  localparam int RS_LSB = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  // True for ops that drive the ALU; 000 and 111 retire without ALU activity
  function automatic logic is_real_op(input logic [OP_W-1:0] op);
    return (op != OP_NOP) && (op != OP_NOP7);
  endfunction

  // True for ops whose ALU result is written back to R[rd]
  function automatic logic writes_back(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/alu_exec_regfile.sv
// 4x8 register file: one write port, three asynchronous read ports.
module alu_exec_regfile
  import alu_exec_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [AW-1:0]     rc_addr,
  output logic [DATA_W-1:0] rc_data
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  // Next register contents: apply the single write port
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  // Register storage, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];
  assign rc_data = regs_q[rc_addr];

endmodule

// File: rtl/alu_exec_seq.sv
// Multi-cycle execute sequencer: accepts one instruction, presents operands
// to the ALU, pulses the ALU control code, then writes back / reports branch.
module alu_exec_seq
  import alu_exec_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              done,
  output logic              branch_taken,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [DATA_W-1:0]  alu_data1_q, alu_data1_d;
  logic [DATA_W-1:0]  alu_data2_q, alu_data2_d;
  logic [OP_W-1:0]    alu_ctrl_q, alu_ctrl_d;

  logic [OP_W-1:0]    in_op;
  logic [AW-1:0]      in_rd;
  logic [AW-1:0]      in_rs;
  logic               instr_unused;

  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic [DATA_W-1:0]  rd_rdata;
  logic [DATA_W-1:0]  rs_rdata;

  assign in_op        = instr[OP_MSB:OP_LSB];
  assign in_rd        = instr[RD_MSB:RD_LSB];
  assign in_rs        = instr[RS_MSB:RS_LSB];
  assign instr_unused = instr[0];

  // Operands are read with the incoming instruction's addresses, so they
  // are already stable on alu_data1/2 before alu_ctrl changes.
  alu_exec_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .ra_addr (in_rd),
    .ra_data (rd_rdata),
    .rb_addr (in_rs),
    .rb_data (rs_rdata),
    .rc_addr (dbg_addr),
    .rc_data (dbg_data)
  );

  // Next-state, ALU drive and writeback/handshake decode
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rd_d         = rd_q;
    alu_data1_d  = alu_data1_q;
    alu_data2_d  = alu_data2_q;
    alu_ctrl_d   = alu_ctrl_q;
    rf_we        = 1'b0;
    rf_waddr     = rd_q;
    rf_wdata     = alu_result;
    instr_ready  = 1'b0;
    done         = 1'b0;
    branch_taken = 1'b0;

    case (state_q)
      ST_IDLE: begin
        instr_ready = !load_en;
        if (load_en) begin
          rf_we    = 1'b1;
          rf_waddr = load_addr;
          rf_wdata = load_data;
        end else if (instr_valid) begin
          op_d = in_op;
          rd_d = in_rd;
          if (is_real_op(in_op)) begin
            alu_data1_d = rd_rdata;
            alu_data2_d = rs_rdata;
            state_d     = ST_SETUP;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_SETUP: begin
        // Operands settled with ctrl at 000; the change to op triggers the ALU
        alu_ctrl_d = op_q;
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        done         = 1'b1;
        branch_taken = (op_q == OP_EQ) && alu_zero;
        rf_we        = writes_back(op_q);
        alu_ctrl_d   = OP_NOP;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A reset in the WB cycle retires nothing
    if (!rst_n) begin
      done         = 1'b0;
      branch_taken = 1'b0;
      rf_we        = 1'b0;
    end
  end

  // Control and ALU-drive registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_data1_q <= '0;
      alu_data2_q <= '0;
      alu_ctrl_q  <= OP_NOP;
    end else begin
      state_q     <= state_d;
      alu_data1_q <= alu_data1_d;
      alu_data2_q <= alu_data2_d;
      alu_ctrl_q  <= alu_ctrl_d;
    end
  end

  // Latched instruction fields; only meaningful while an op is in flight
  always_ff @(posedge clk) begin
    op_q <= op_d;
    rd_q <= rd_d;
  end

  assign alu_data1 = alu_data1_q;
  assign alu_data2 = alu_data2_q;
  assign alu_ctrl  = alu_ctrl_q;

endmodule

// File: doc/alu_exec_seq.md
# alu_exec_seq

Multi-cycle execute sequencer for the 8-bit datapath, sitting directly upstream of the ALU. It accepts one decoded instruction at a time over a valid/ready handshake and reads two operands from an internal 4x8 register file. It drives the ALU operand and control inputs in a fixed sequence, then writes the ALU result back and reports the branch outcome of equality tests. The ALU re-evaluates only when its control code changes, so the sequencer always returns that code to 3'b000 between operations.

## Interface
- NREG, 4: register-file depth, fixed; address width 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- instr_valid  in  1  upstream presents an instruction.
- instr_ready  out  1  high only in IDLE with load_en low.
- instr  in  8  [7:5] op, [4:3] rd, [2:1] rs, [0] ignored.
- load_en  in  1  register preload strobe, honoured only in IDLE.
- load_addr  in  2  preload address.
- load_data  in  8  preload value.
- alu_data1  out  8  registered R[rd], to ALU data1.
- alu_data2  out  8  registered R[rs], to ALU data2.
- alu_ctrl  out  3  registered ALU control code.
- alu_result  in  8  ALU result.
- alu_zero  in  1  ALU equality flag.
- done  out  1  one-cycle pulse when an instruction retires.
- branch_taken  out  1  valid with done; 1 only for op 3'b110 with alu_zero=1.
- dbg_addr  in  2  debug read address.
- dbg_data  out  8  combinational R[dbg_addr].

## Operation
- Op codes: 001 add, 010 nand, 011 compare, 100 shl, 101 shr, 110 equal. Codes 000 and 111 are NOP.
- States: IDLE, SETUP, EXEC, WB.
- IDLE:
  - If load_en=1, R[load_addr] <= load_data; instr_ready=0.
  - Else if instr_valid=1, latch op/rd/rs.
    - For a real op, go to SETUP.
    - For a NOP, go to WB with no ALU activity.
- SETUP:
  - alu_data1 <= R[rd]; alu_data2 <= R[rs]; alu_ctrl held at 3'b000.
  - Go to EXEC.
- EXEC:
  - alu_ctrl <= op (the ALU evaluates on this change).
  - Go to WB.
- WB:
  - done=1.
  - For ops 001–101, R[rd] <= alu_result. Compare writes whatever value alu_result returns.
  - For op 110, there is no writeback and branch_taken=alu_zero.
  - alu_ctrl <= 3'b000.
  - Go to IDLE.
- shl and shr ignore alu_data2, but it is still loaded.
- rd == rs is legal: both operands equal R[rd].
- load_en and instr_valid are ignored outside IDLE. Upstream must hold instr_valid until instr_ready.

## Timing
- Reset values:
  - All registers R0–R3 = 0.
  - State IDLE.
  - alu_data1, alu_data2 = 0; alu_ctrl = 3'b000.
  - done = 0, branch_taken = 0.
  - instr_ready = 1 from the first cycle after reset.
- Real op accepted on edge T:
  - SETUP at T+1.
  - EXEC at T+2; alu_ctrl=op from T+2.
  - WB at T+3: done and branch_taken high during T+3, R[rd] updated at the end of T+3.
  - IDLE at T+4.
- Throughput is one real op per 4 cycles.
- NOP accepted at T: done pulses at T+1 with branch_taken=0, back in IDLE at T+2.
- Back-to-back ops: an instruction issued at T+4 reads the value written in T+3; no hazard is possible.
- Reset asserted in any state: return to IDLE next edge with no writeback. A pending done is suppressed.
- dbg_data is combinational and shows the pre-write value during the WB cycle.

## Structure
- Shared package: op-code constants (OP_NOP, OP_ADD, OP_NAND, OP_CMP, OP_SHL, OP_SHR, OP_EQ), state encoding, and instruction field positions.
- One sub-module, alu_exec_regfile: 4x8 registers with one write port (muxed between preload and writeback) and three read ports (rd, rs, dbg).
- FSM and ALU-drive registers live in the top module.

## Test plan
- Reset mid-op:
  - Preload R1=0x05, R2=0x09.
  - Issue add rd=1 rs=2, assert rst_n=0 in EXEC.
  - Expect no done, R1=0x00, instr_ready=1 after release.
- Add:
  - Preload R1=0x05, R2=0x09, issue add rd=1 rs=2.
  - Expect alu_ctrl 000→001 at T+2, done at T+3, R1=0x0E.
- NAND then shift right on the result:
  - Preload R0=0xF0, R3=0x3C, issue nand rd=0 rs=3.
  - Expect R0=0xCF.
  - Then issue shr rd=0 rs=0 and expect alu_data1=0xCF and done.
- Equal, both outcomes:
  - R1=R2=0x42: equal rd=1 rs=2 gives done with branch_taken=1 and no register change.
  - Load R2=0x43: equal rd=1 rs=2 gives branch_taken=0.
- Priority and handshake:
  - Load and instr_valid together in IDLE: load wins and instr_ready=0.
  - The instruction is accepted next cycle.
  - instr_valid held during SETUP/EXEC/WB does not cause a second accept.
- NOP, op 111:
  - Expect done at T+1, branch_taken=0, alu_ctrl stays 000, all registers unchanged.
